cpu_main_memory: RTL and testbench

- Line-granular main-memory model on the CPU memory bus, directly downstream of the commit stage's data cache.
- Accepts one line read or line write at a time from the mem-bus request interface.
- Holds the bus busy (mem_bus_available low) for a programmable latency, then commits the write or returns the read line on the mem-bus response interface.
- Used as the cache refill/write-back target in simulation and as the bus slave template for the FPGA build.

---
 rtl/cpu_main_memory.sv | 142 ++++++++++++++
 tb/tb_cpu_main_memory.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_main_memory.sv
// Line-granular main memory behind the data cache.
// One line read or write at a time, completed after a fixed latency.
module cpu_main_memory #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_bus_available,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0] resp_data
);

    localparam int OFFS = $clog2(LINE_WIDTH / 8);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = 8;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;

    // Zero at time 0 only; reset deliberately leaves contents alone.
    logic [LINE_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic            accept;
    logic            done;
    logic [IDXW-1:0] idx;

    assign accept = (state_q == IDLE) && (req_read || req_write);
    assign done   = (state_q == BUSY) && (cnt_q == '0);
    assign idx    = addr_q[OFFS +: IDXW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = wr_q ? IDLE : RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_bus_available = 1'b0;
        resp_valid        = 1'b0;
        unique case (state_q)
            IDLE:    mem_bus_available = 1'b1;
            BUSY:    mem_bus_available = 1'b0;
            RESPOND: resp_valid        = 1'b1;
            default: mem_bus_available = 1'b0;
        endcase
    end

    // Write wins when both request lines are raised together.
    always_comb begin
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_addr_d = resp_addr_q;
        resp_data_d = resp_data_q;
        if (accept) begin
            cnt_d  = CNT_INIT;
            wr_d   = req_write;
            addr_d = req_addr & ~OFF_MASK;
            data_d = req_data;
        end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (done && !wr_q) begin
            resp_addr_d = addr_q;
            resp_data_d = mem_q[idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_addr_q <= '0;
            resp_data_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_addr_q <= resp_addr_d;
            resp_data_q <= resp_data_d;
        end
    end

    // A reset forces IDLE, so an aborted write never reaches the array.
    always_ff @(posedge clock) begin
        if (done && wr_q) begin
            mem_q[idx] <= data_q;
        end
    end

    assign resp_addr = resp_addr_q;
    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_cpu_main_memory.sv
// Directed bench for cpu_main_memory.
// Hand-computed expectations, LATENCY=4, DEPTH=1024.
module tb_cpu_main_memory;

    logic         clock;
    logic         reset;
    logic         mem_bus_available;
    logic         req_read;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [127:0] resp_data;

    int n_asserts;
    int n_fail;

    cpu_main_memory #(
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .DEPTH(1024),
        .LATENCY(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_bus_available(mem_bus_available),
        .req_read(req_read),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_data(req_data),
        .resp_valid(resp_valid),
        .resp_addr(resp_addr),
        .resp_data(resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_line(input string tag,
                              input logic [31:0] a,
                              input logic [127:0] d,
                              input logic both);
        int busy;
        logic saw_resp;
        req_write = 1'b1;
        req_read  = both;
        req_addr  = a;
        req_data  = d;
        tick();
        req_write = 1'b0;
        req_read  = 1'b0;
        busy      = 0;
        saw_resp  = 1'b0;
        while (!mem_bus_available && busy < 20) begin
            busy++;
            if (resp_valid) saw_resp = 1'b1;
            tick();
        end
        if (resp_valid) saw_resp = 1'b1;
        check({tag, "_busy"}, 128'(busy), 128'd4);
        check({tag, "_noresp"}, 128'(saw_resp), 128'd0);
    endtask

    task automatic read_line(input string tag,
                             input logic [31:0] a,
                             input logic [31:0] exp_a,
                             input logic [127:0] exp_d);
        int n;
        req_read = 1'b1;
        req_addr = a;
        tick();
        req_read = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_valid && n < 20);
        check({tag, "_lat"}, 128'(n), 128'd4);
        check({tag, "_addr"}, 128'(resp_addr), 128'(exp_a));
        check({tag, "_data"}, resp_data, exp_d);
        check({tag, "_busy"}, 128'(mem_bus_available), 128'd0);
        tick();
        check({tag, "_pulse"}, 128'(resp_valid), 128'd0);
        check({tag, "_idle"}, 128'(mem_bus_available), 128'd1);
        check({tag, "_hold"}, resp_data, exp_d);
    endtask

    logic [127:0] d_ff;
    logic [127:0] d_a5;
    logic [127:0] d_11;
    logic [127:0] d_de;
    int n;

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        d_ff = {4{32'hFFEEDDCC}};
        d_a5 = {16{8'hA5}};
        d_11 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        d_de = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

        #3;
        check("rst_avail", 128'(mem_bus_available), 128'd1);
        check("rst_valid", 128'(resp_valid), 128'd0);
        check("rst_addr", 128'(resp_addr), 128'd0);
        check("rst_data", resp_data, 128'd0);
        #10 reset = 1'b1;
        tick();
        check("rel_avail", 128'(mem_bus_available), 128'd1);
        check("rel_valid", 128'(resp_valid), 128'd0);

        write_line("wr20", 32'h20, d_ff, 1'b0);
        read_line("rd2c", 32'h2C, 32'h20, d_ff);

        read_line("rd100", 32'h100, 32'h100, 128'd0);

        write_line("wr0", 32'h0, d_a5, 1'b0);
        read_line("rd4000", 32'h4000, 32'h4000, d_a5);

        write_line("both40", 32'h40, d_11, 1'b1);
        read_line("rd40", 32'h40, 32'h40, d_11);

        // Abort a write two cycles in; the line must stay zero.
        req_write = 1'b1;
        req_addr  = 32'h80;
        req_data  = d_de;
        tick();
        req_write = 1'b0;
        tick();
        tick();
        check("ab_busy", 128'(mem_bus_available), 128'd0);
        #2 reset = 1'b0;
        #1;
        check("ab_avail", 128'(mem_bus_available), 128'd1);
        tick();
        #3 reset = 1'b1;
        tick();
        read_line("rd80", 32'h80, 32'h80, 128'd0);

        // Reset during RESPOND drops resp_valid without a clock edge.
        req_read = 1'b1;
        req_addr = 32'h20;
        tick();
        req_read = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_valid && n < 20);
        check("mr_valid", 128'(resp_valid), 128'd1);
        #2 reset = 1'b0;
        #1;
        check("mr_drop", 128'(resp_valid), 128'd0);
        check("mr_avail", 128'(mem_bus_available), 128'd1);
        #2 reset = 1'b1;
        tick();

        // Read raised while a write is busy waits for IDLE.
        req_write = 1'b1;
        req_addr  = 32'hC0;
        req_data  = d_de;
        tick();
        req_write = 1'b0;
        req_read  = 1'b1;
        req_addr  = 32'hC4;
        n = 0;
        do begin
            tick();
            n++;
        end while (!resp_valid && n < 20);
        req_read = 1'b0;
        check("bi_lat", 128'(n), 128'd9);
        check("bi_addr", 128'(resp_addr), 128'hC0);
        check("bi_data", resp_data, d_de);
        tick();
        check("bi_pulse", 128'(resp_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
